// File: rtl/sonar_range_bcd_pkg.sv
// rtl/sonar_range_bcd_pkg.sv - shared FSM states, iteration counts and divisor helper
// for the sonar range converter.
package sonar_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_ITERS = 32;
  localparam int BCD_ITERS = 10;

  // Whole clock cycles per microsecond times round-trip microseconds per cm.
  function automatic int cyc_per_cm(input int clk_freq, input int us_per_cm);
    return (clk_freq / 1_000_000) * us_per_cm;
  endfunction

endpackage

// File: rtl/sonar_range_bcd_if.sv
// rtl/sonar_range_bcd_if.sv - echo measurement input and BCD display output bundle.
interface sonar_range_bcd_if;

  logic [31:0] in_width;
  logic        in_timeout;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  bcd_hund;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic        out_of_range;
  logic        out_valid;

  modport master (
    output in_width, in_timeout, in_valid,
    input  in_ready, bcd_hund, bcd_tens, bcd_ones, out_of_range, out_valid
  );

  modport slave (
    input  in_width, in_timeout, in_valid,
    output in_ready, bcd_hund, bcd_tens, bcd_ones, out_of_range, out_valid
  );

endinterface

// File: rtl/sonar_range_bcd_bin2bcd_seq.sv
// rtl/sonar_range_bcd_bin2bcd_seq.sv - 10-bit binary to three BCD digits by sequential
// double-dabble, one shift per cycle.
module bin2bcd_seq
  import sonar_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [9:0] bin_i,
  output logic       done_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  localparam logic [3:0] LAST_ITER = 4'(BCD_ITERS - 1);

  // Digits live in [21:10]; the binary value shifts out of [9:0].
  logic [21:0] sr_q;
  logic [21:0] adj;
  logic [3:0]  cnt_q;
  logic        busy_q;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[10+4*i +: 4] >= 4'd5) begin
        adj[10+4*i +: 4] = sr_q[10+4*i +: 4] + 4'd3;
      end
    end
  end

  // Asserted during the cycle whose closing edge performs the final shift.
  assign done_o = busy_q && (cnt_q == LAST_ITER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      sr_q   <= {12'd0, bin_i};
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sr_q  <= adj << 1;
      cnt_q <= cnt_q + 4'd1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign hund_o = sr_q[21:18];
  assign tens_o = sr_q[17:14];
  assign ones_o = sr_q[13:10];

endmodule

// File: rtl/sonar_range_bcd.sv
// rtl/sonar_range_bcd.sv - echo width to centimetres via restoring division, range clamp,
// then BCD digits for the display driver; fixed 43-cycle latency.
module sonar_range_bcd
  import sonar_pkg::*;
#(
  parameter int clk_freq  = 125_000_000,
  parameter int US_PER_CM = 58,
  parameter int MAX_CM    = 400
) (
  input logic               clk,
  input logic               rst,
  sonar_range_bcd_if.slave  bus
);

  localparam int          CYC_PER_CM = cyc_per_cm(clk_freq, US_PER_CM);
  localparam logic [32:0] DIVISOR    = 33'(CYC_PER_CM);
  localparam logic [4:0]  LAST_DIV   = 5'(DIV_ITERS - 1);

  state_t      state_q, state_d;
  logic [31:0] work_q;
  logic [32:0] rem_q;
  logic [4:0]  cnt_q;
  logic        timeout_q;
  logic        range_q;
  logic [3:0]  hund_q, tens_q, ones_q;
  logic        out_of_range_q;
  logic        out_valid_q;

  logic [32:0] rem_shift;
  logic [32:0] rem_step;
  logic        q_bit;
  logic [31:0] quot_next;
  logic        over;
  logic [9:0]  bcd_bin;
  logic        bcd_start;
  logic        bcd_done;
  logic [3:0]  bcd_h, bcd_t, bcd_o;

  // work_q starts as the dividend; quotient bits enter at the LSB as dividend bits leave the MSB.
  always_comb begin
    rem_shift = {rem_q[31:0], work_q[31]};
    q_bit     = rem_q[32] || (rem_shift >= DIVISOR);
    rem_step  = q_bit ? (rem_shift - DIVISOR) : rem_shift;
    quot_next = {work_q[30:0], q_bit};
    over      = (quot_next > 32'(MAX_CM)) || timeout_q;
    bcd_bin   = over ? 10'd999 : quot_next[9:0];
    bcd_start = (state_q == DIV) && (cnt_q == LAST_DIV);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = DIV;
      DIV:  if (cnt_q == LAST_DIV) state_d = BCD;
      BCD:  if (bcd_done) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      work_q         <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      range_q        <= 1'b0;
      hund_q         <= '0;
      tens_q         <= '0;
      ones_q         <= '0;
      out_of_range_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q    <= bus.in_width;
            timeout_q <= bus.in_timeout;
            rem_q     <= '0;
            cnt_q     <= '0;
          end
        end
        DIV: begin
          work_q <= quot_next;
          rem_q  <= rem_step;
          cnt_q  <= cnt_q + 5'd1;
          if (bcd_start) begin
            range_q <= over;
          end
        end
        DONE: begin
          hund_q         <= bcd_h;
          tens_q         <= bcd_t;
          ones_q         <= bcd_o;
          out_of_range_q <= range_q;
          out_valid_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (bcd_start),
    .bin_i   (bcd_bin),
    .done_o  (bcd_done),
    .hund_o  (bcd_h),
    .tens_o  (bcd_t),
    .ones_o  (bcd_o)
  );

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.bcd_hund     = hund_q;
  assign bus.bcd_tens     = tens_q;
  assign bus.bcd_ones     = ones_q;
  assign bus.out_of_range = out_of_range_q;
  assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_sonar_range_bcd.sv
// tb/tb_sonar_range_bcd.sv - directed bench for sonar_range_bcd at default parameters.
module tb_sonar_range_bcd;

  localparam int CYC = 7250;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sonar_range_bcd_if bus();

  sonar_range_bcd #(
    .clk_freq  (125_000_000),
    .US_PER_CM (58),
    .MAX_CM    (400)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_width = '0;
    bus.in_timeout = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_of_range, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}
        !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b oor=%b bcd=%h, expected rdy=1 ov=0 oor=0 bcd=000",
               bus.in_ready, bus.out_valid, bus.out_of_range,
               {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones});
    end
    rst = 1'b1;
  endtask

  task automatic run_conv(input string name, input logic [31:0] w, input logic to,
                          input logic [11:0] exp_bcd, input logic exp_flag);
    logic window_ok;
    int   bad_k;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b, expected 1", name, bus.in_ready);
    end
    bus.in_width = w;
    bus.in_timeout = to;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_width = 32'hDEAD_BEEF;
    bus.in_timeout = 1'b0;
    window_ok = 1'b1;
    bad_k = -1;
    for (int k = 1; k < 43; k++) begin
      step();
      if ((bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) && window_ok) begin
        window_ok = 1'b0;
        bad_k = k;
      end
    end
    checks++;
    if (!window_ok) begin
      errors++;
      $display("FAIL %s busy_window: at edge %0d got rdy=%b ov=%b, expected rdy=0 ov=0",
               name, bad_k, bus.in_ready, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s edge43_pulse: got ov=%b rdy=%b, expected ov=1 rdy=1",
               name, bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.out_of_range} !== {exp_bcd, exp_flag}) begin
      errors++;
      $display("FAIL %s result: got bcd=%h oor=%b, expected bcd=%h oor=%b", name,
               {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, bus.out_of_range, exp_bcd, exp_flag);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 ||
        {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.out_of_range} !== {exp_bcd, exp_flag}) begin
      errors++;
      $display("FAIL %s hold_after_pulse: got ov=%b bcd=%h oor=%b, expected ov=0 bcd=%h oor=%b",
               name, bus.out_valid, {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones},
               bus.out_of_range, exp_bcd, exp_flag);
    end
  endtask

  task automatic test_values();
    run_conv("w725000", 32'd725_000, 1'b0, 12'h100, 1'b0);
    run_conv("w7249", 32'd7_249, 1'b0, 12'h000, 1'b0);
    run_conv("w15000", 32'd15_000, 1'b0, 12'h002, 1'b0);
    run_conv("w0", 32'd0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic test_range();
    run_conv("w2907249", 32'd2_907_249, 1'b0, 12'h400, 1'b0);
    run_conv("w2907250", 32'd2_907_250, 1'b0, 12'h999, 1'b1);
    run_conv("wmax", 32'hFFFF_FFFF, 1'b0, 12'h999, 1'b1);
    run_conv("w2907249_again", 32'd2_907_249, 1'b0, 12'h400, 1'b0);
  endtask

  task automatic test_timeout();
    run_conv("timeout", 32'd1_000, 1'b1, 12'h999, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic seq_ok;
    int   bad_j;
    seq_ok = 1'b1;
    bad_j = -1;
    for (int j = 0; j < 132; j++) begin
      bus.in_width = 32'(CYC * (j + 3) + 5);
      bus.in_timeout = 1'b0;
      bus.in_valid = 1'b1;
      step();
      if ((j % 44) == 43) begin
        checks++;
        if (bus.out_valid !== 1'b1 ||
            {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones, bus.out_of_range} !== {to_bcd(j - 40), 1'b0}) begin
          errors++;
          $display("FAIL b2b_result_%0d: got ov=%b bcd=%h oor=%b, expected ov=1 bcd=%h oor=0", j,
                   bus.out_valid, {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones},
                   bus.out_of_range, to_bcd(j - 40));
        end
      end
      if ((bus.out_valid !== 1'((j % 44) == 43) || bus.in_ready !== 1'((j % 44) == 43)) && seq_ok) begin
        seq_ok = 1'b0;
        bad_j = j;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL b2b_handshake: at edge %0d got ov=%b rdy=%b, expected both %b",
               bad_j, bus.out_valid, bus.in_ready, 1'((bad_j % 44) == 43));
    end
  endtask

  task automatic test_reset_mid();
    logic quiet_ok;
    bus.in_width = 32'd725_000;
    bus.in_timeout = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (20) step();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_of_range, bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}
        !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL midreset_state: got rdy=%b ov=%b oor=%b bcd=%h, expected rdy=1 ov=0 oor=0 bcd=000",
               bus.in_ready, bus.out_valid, bus.out_of_range,
               {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones});
    end
    quiet_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.out_valid !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok) begin
      errors++;
      $display("FAIL midreset_quiet: got out_valid=1 during reset, expected 0");
    end
    rst = 1'b1;
    run_conv("after_reset", 32'd725_000, 1'b0, 12'h100, 1'b0);
  endtask

  initial begin
    test_reset();
    test_values();
    test_range();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
